// File: rtl/wishbone_master_port_if.sv
// Wishbone classic signal bundle shared by the initiator port and the slaves on the interconnect.
`timescale 1ns/1ps
interface wishbone_interface;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_mosi;
   logic [31:0] dat_miso;
   logic        ack;
   logic        err;

   modport master (
      output cyc, stb, we, adr, sel, dat_mosi,
      input  ack, err, dat_miso
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_mosi,
      output ack, err, dat_miso
   );
endinterface

// File: rtl/wishbone_master_port.sv
// Wishbone classic initiator: one valid/ready request becomes one non-pipelined bus cycle,
// answered by a single-cycle response; a watchdog aborts cycles nobody acknowledges.
`timescale 1ns/1ps
module wishbone_master_port #(
   parameter int unsigned TIMEOUT_CYCLES = 32'd64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_sel,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              busy,
   wishbone_interface.master wishbone
);
   localparam int unsigned   CW       = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned   LAST     = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(LAST);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] wd_cnt;
   logic          cyc_q, stb_q, we_q;
   logic [31:0]   adr_q, dat_q;
   logic [3:0]    sel_q;
   logic          start, done_ack, done_err, done_to, done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (start) state_nxt = ST_WAIT;
         ST_WAIT: if (done)  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // err outranks ack, and either outranks a watchdog expiry on the same edge
   always_comb begin
      req_ready = (state == ST_IDLE);
      start     = 1'b0;
      done_ack  = 1'b0;
      done_err  = 1'b0;
      done_to   = 1'b0;
      if (state == ST_IDLE)
         start = req_valid;
      else if (wishbone.err)
         done_err = 1'b1;
      else if (wishbone.ack)
         done_ack = 1'b1;
      else if (TIMEOUT_CYCLES != 0 && wd_cnt == CNT_LAST)
         done_to = 1'b1;
   end

   assign done = done_ack | done_err | done_to;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         sel_q       <= '0;
         dat_q       <= '0;
         wd_cnt      <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_rdata   <= '0;
      end else begin
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         if (start) begin
            cyc_q  <= 1'b1;
            stb_q  <= 1'b1;
            we_q   <= req_we;
            adr_q  <= req_addr;
            sel_q  <= req_sel;
            dat_q  <= req_wdata;
            wd_cnt <= '0;
         end else if (state == ST_WAIT) begin
            if (wd_cnt != CNT_MAX) wd_cnt <= wd_cnt + CW'(1);
            if (done) begin
               cyc_q       <= 1'b0;
               stb_q       <= 1'b0;
               rsp_valid   <= 1'b1;
               rsp_err     <= done_err | done_to;
               rsp_timeout <= done_to;
               rsp_rdata   <= (done_ack && !we_q) ? wishbone.dat_miso : '0;
            end
         end
      end
   end

   assign wishbone.cyc      = cyc_q;
   assign wishbone.stb      = stb_q;
   assign wishbone.we       = we_q;
   assign wishbone.adr      = adr_q;
   assign wishbone.sel      = sel_q;
   assign wishbone.dat_mosi = dat_q;
   assign busy              = cyc_q;
endmodule

// File: tb/tb_wishbone_master_port.sv
// Scoreboard bench for wishbone_master_port with a registered-ack slave model and ack/err injection.
`timescale 1ns/1ps
module tb_wishbone_master_port;
   localparam logic [31:0] ADDRESS  = 32'h0000_1000;
   localparam logic [31:0] DEAD_ADR = 32'h0000_2000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_sel = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        busy;

   always #5 clk = ~clk;

   wishbone_interface wb();

   wishbone_master_port #(.TIMEOUT_CYCLES(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_sel     (req_sel),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .busy        (busy),
      .wishbone    (wb)
   );

   // slave model: timer at ADDRESS+0 reads 10, byte-enabled register at ADDRESS+3,
   // DEAD_ADR never answers, everything else returns err
   logic        s_ack, s_err;
   logic [31:0] s_dat, s_reg;
   logic        inj_ack = 1'b0;
   logic        inj_err = 1'b0;
   logic [31:0] inj_dat = 32'hCAFE_F00D;

   assign wb.ack      = s_ack | inj_ack;
   assign wb.err      = s_err | inj_err;
   assign wb.dat_miso = inj_ack ? inj_dat : s_dat;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ack <= 1'b0;
         s_err <= 1'b0;
         s_dat <= '0;
         s_reg <= '0;
      end else begin
         s_ack <= 1'b0;
         s_err <= 1'b0;
         if (wb.cyc && wb.stb && !s_ack && !s_err) begin
            if (wb.adr == ADDRESS) begin
               s_ack <= 1'b1;
               s_dat <= wb.we ? 32'h0 : 32'h0000_000A;
            end else if (wb.adr == ADDRESS + 32'd3) begin
               s_ack <= 1'b1;
               if (wb.we) begin
                  for (int b = 0; b < 4; b++)
                     if (wb.sel[b]) s_reg[8*b +: 8] <= wb.dat_mosi[8*b +: 8];
                  s_dat <= '0;
               end else begin
                  s_dat <= s_reg;
               end
            end else if (wb.adr != DEAD_ADR) begin
               s_err <= 1'b1;
            end
         end
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        to;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every response pulse must match the oldest pending expectation
   exp_t m_e;
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_rsp: got rdata=%h err=%b to=%b expected no response",
                     rsp_rdata, rsp_err, rsp_timeout);
         end else begin
            m_e = sb.pop_front();
            if (rsp_rdata !== m_e.rdata || rsp_err !== m_e.err || rsp_timeout !== m_e.to) begin
               failures++;
               $display("FAIL rsp: got rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
                        rsp_rdata, rsp_err, rsp_timeout, m_e.rdata, m_e.err, m_e.to);
            end
         end
      end
   end

   // issue one request from a negedge; returns edges from handshake to response and stb-high cycles
   task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                        input logic [3:0] sel, input logic [31:0] exp_rd, input logic exp_err,
                        input logic exp_to, input int inj_cyc, input logic ia, input logic ie,
                        output int lat, output int stbc);
      int  wt;
      bit  got;
      wt = 0;
      while (!req_ready && wt < 50) begin
         @(negedge clk);
         wt++;
      end
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = adr;
      req_wdata = wdata;
      req_sel   = sel;
      sb.push_back('{rdata: exp_rd, err: exp_err, to: exp_to});
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat  = 1;
      stbc = 0;
      got  = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (j == inj_cyc + 1) begin
            inj_ack = 1'b0;
            inj_err = 1'b0;
         end
         if (rsp_valid) begin
            got = 1'b1;
            break;
         end
         if (wb.stb) stbc++;
         if (j == inj_cyc) begin
            inj_ack = ia;
            inj_err = ie;
         end
         @(posedge clk);
         lat++;
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL no_rsp: got no rsp_valid within 40 cycles expected a response");
         inj_ack = 1'b0;
         inj_err = 1'b0;
      end
      chk("cyc_stb_busy_dropped", 32'({wb.cyc, wb.stb, busy}), 32'd0);
   endtask

   int lat, stbc;

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_cyc_stb", 32'({wb.cyc, wb.stb}), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_adr", wb.adr, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_ready", 32'(req_ready), 32'd1);
      chk("post_reset_busy", 32'(busy), 32'd0);

      // timer read
      issue(1'b0, ADDRESS, 32'h0, 4'hF, 32'h0000_000A, 1'b0, 1'b0, -1, 1'b0, 1'b0, lat, stbc);
      chk("read_latency", 32'(lat), 32'd3);
      chk("read_stb_cycles", 32'(stbc), 32'd2);

      // byte-enabled writes and readback, back to back
      issue(1'b1, ADDRESS + 32'd3, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1'b0, 1'b0, -1, 1'b0, 1'b0, lat, stbc);
      chk("write_latency", 32'(lat), 32'd3);
      issue(1'b0, ADDRESS + 32'd3, 32'hFFFF_FFFF, 4'hF, 32'h0000_BEEF, 1'b0, 1'b0, -1, 1'b0, 1'b0, lat, stbc);
      issue(1'b1, ADDRESS + 32'd3, 32'h1234_5678, 4'b1100, 32'h0, 1'b0, 1'b0, -1, 1'b0, 1'b0, lat, stbc);
      issue(1'b0, ADDRESS + 32'd3, 32'h0, 4'hF, 32'h1234_BEEF, 1'b0, 1'b0, -1, 1'b0, 1'b0, lat, stbc);

      // unmapped addresses answer with err
      issue(1'b0, ADDRESS + 32'd5, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, -1, 1'b0, 1'b0, lat, stbc);
      chk("err_latency", 32'(lat), 32'd3);
      issue(1'b1, ADDRESS + 32'd1, 32'h5555_5555, 4'hF, 32'h0, 1'b1, 1'b0, -1, 1'b0, 1'b0, lat, stbc);

      // watchdog abort, then a late ack is ignored
      issue(1'b0, DEAD_ADR, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, -1, 1'b0, 1'b0, lat, stbc);
      chk("timeout_stb_cycles", 32'(stbc), 32'd8);
      chk("timeout_latency", 32'(lat), 32'd9);
      repeat (3) @(negedge clk);
      inj_ack = 1'b1;
      @(negedge clk);
      chk("late_ack_no_rsp", 32'(rsp_valid), 32'd0);
      inj_ack = 1'b0;
      chk("late_ack_ready", 32'(req_ready), 32'd1);
      chk("late_ack_busy", 32'(busy), 32'd0);

      // ack / err on the expiry edge win over the watchdog
      issue(1'b0, DEAD_ADR, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0, 7, 1'b1, 1'b0, lat, stbc);
      chk("expiry_ack_latency", 32'(lat), 32'd9);
      issue(1'b1, DEAD_ADR, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 7, 1'b1, 1'b0, lat, stbc);
      issue(1'b0, DEAD_ADR, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 7, 1'b0, 1'b1, lat, stbc);
      issue(1'b0, DEAD_ADR, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 2, 1'b1, 1'b1, lat, stbc);
      chk("ack_err_latency", 32'(lat), 32'd4);

      // asynchronous reset in the middle of a cycle
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = DEAD_ADR;
      req_sel   = 4'hF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("stb_before_reset", 32'(wb.stb), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_cyc_stb", 32'({wb.cyc, wb.stb, busy}), 32'd0);
      chk("async_reset_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_release_ready", 32'(req_ready), 32'd1);
      chk("reset_release_rsp", 32'(rsp_valid), 32'd0);
      issue(1'b0, ADDRESS, 32'h0, 4'hF, 32'h0000_000A, 1'b0, 1'b0, -1, 1'b0, 1'b0, lat, stbc);
      chk("after_reset_latency", 32'(lat), 32'd3);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL global_timeout: got no completion expected finish before 200us");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "simulation time limit");
   end
endmodule
